// File: rtl/bcd_stopwatch_ctrl.sv
// bcd_stopwatch_ctrl
//   Run/pause/clear controller for a cascaded bcd_1digit stopwatch chain.
//   Turns one-cycle button pulses into IDLE/RUN/PAUSE(/HALT) states, derives
//   the chain count tick from a DIV-cycle prescaler, and drives a display
//   register that can be frozen for lap times.
//
//   Optional feature macro: STOPWATCH_AUTO_STOP_EN
//     defined   : reaching all nines halts the watch (HALT state, display
//                 saturated at all nines, only btn_clr leaves HALT).
//     undefined : the chain wraps to zero, ovf is set, counting continues.
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   btn_ss       start/stop pulse
//   btn_lap      lap pulse
//   btn_clr      clear pulse
//   digits       chain value, digit 0 in [3:0]
//   cnt_en       count tick to the chain enable
//   cnt_clr      one-cycle chain clear pulse (one cycle after the clear edge)
//   disp         display value
//   running      high in RUN
//   lap_active   display frozen
//   ovf          sticky overflow flag
module bcd_stopwatch_ctrl #(
  parameter int N_DIGITS = 4,
  parameter int DIV      = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_ss,
  input  logic                  btn_lap,
  input  logic                  btn_clr,
  input  logic [4*N_DIGITS-1:0] digits,
  output logic                  cnt_en,
  output logic                  cnt_clr,
  output logic [4*N_DIGITS-1:0] disp,
  output logic                  running,
  output logic                  lap_active,
  output logic                  ovf
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

`ifdef STOPWATCH_AUTO_STOP_EN
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, HALT} state_t;
  localparam logic [4*N_DIGITS-1:0] ALL9 = {N_DIGITS{4'h9}};
`else
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
`endif

  state_t        state, state_nxt;
  logic [PW-1:0] pre;
  logic          lap_nxt, tick, ovf_set, pre_adv, all9, clr_q;

  always_comb begin
    all9 = 1'b1;
    for (int i = 0; i < N_DIGITS; i++)
      if (digits[4*i +: 4] != 4'd9) all9 = 1'b0;
  end

  always_comb begin
    state_nxt = state;
    lap_nxt   = lap_active;
    tick      = 1'b0;
    ovf_set   = 1'b0;
    if (btn_clr) begin
      state_nxt = IDLE;
      lap_nxt   = 1'b0;
    end else begin
      if (btn_ss) begin
        case (state)
          IDLE, PAUSE: state_nxt = RUN;
          RUN:         state_nxt = PAUSE;
          default:     state_nxt = state;  // HALT ignores start/stop
        endcase
      end else if (btn_lap) begin
        lap_nxt = (state == RUN) ? !lap_active : 1'b0;
      end
      // Tick decision; a pause in the same cycle swallows the tick.
      if (!btn_ss && state == RUN && pre == PRE_MAX) begin
`ifdef STOPWATCH_AUTO_STOP_EN
        if (all9) begin
          state_nxt = HALT;
          ovf_set   = 1'b1;
        end else begin
          tick = 1'b1;
        end
`else
        tick    = 1'b1;
        ovf_set = all9;
`endif
      end
    end
    // Prescaler only advances while staying in RUN, so a pause keeps the
    // partial period and resume finishes it.
    pre_adv = (state == RUN) && (state_nxt == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pre        <= '0;
      cnt_en     <= 1'b0;
      clr_q      <= 1'b0;
      cnt_clr    <= 1'b0;
      disp       <= '0;
      lap_active <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt_en     <= tick;
      clr_q      <= btn_clr;
      cnt_clr    <= clr_q;
      lap_active <= lap_nxt;
      ovf        <= btn_clr ? 1'b0 : (ovf | ovf_set);
      if (btn_clr)      pre <= '0;
      else if (pre_adv) pre <= (pre == PRE_MAX) ? '0 : pre + 1'b1;
`ifdef STOPWATCH_AUTO_STOP_EN
      if (state == HALT)    disp <= ALL9;
      else if (!lap_active) disp <= digits;
`else
      if (!lap_active) disp <= digits;
`endif
    end
  end

  assign running = (state == RUN);

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
module tb_bcd_stopwatch_ctrl;
  localparam int N   = 2;
  localparam int DIV = 4;

  logic         clk = 1'b0;
  logic         rst, btn_ss, btn_lap, btn_clr;
  logic [4*N-1:0] digits, disp;
  logic         cnt_en, cnt_clr, running, lap_active, ovf;
  logic [7:0]   chain;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  bcd_stopwatch_ctrl #(.N_DIGITS(N), .DIV(DIV)) dut (
    .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_lap(btn_lap),
    .btn_clr(btn_clr), .digits(digits), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
    .disp(disp), .running(running), .lap_active(lap_active), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference digit chain: 2-digit BCD counter cleared by rst | cnt_clr.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (r[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (r[7:4] == 4'd9) ? 4'd0 : r[7:4] + 4'd1;
    end else begin
      r[3:0] = r[3:0] + 4'd1;
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) chain <= '0;
    else if (cnt_en)    chain <= bcd_inc(chain);
  end
  assign digits = chain;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic chk(input logic [31:0] obs);
    string t;
    logic [31:0] e;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
    end
  endtask

  // Steps until cnt_en is seen; n = cycles waited, or -1 on timeout.
  task automatic wait_tick(output int n, input int lim);
    n = -1;
    for (int i = 1; i <= lim; i++) begin
      step();
      if (cnt_en) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_chain(input logic [7:0] v, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (chain == v) break;
      step();
    end
  endtask

  task automatic press(input logic s, input logic l, input logic c);
    btn_ss = s; btn_lap = l; btn_clr = c;
    step();
    btn_ss = 0; btn_lap = 0; btn_clr = 0;
  endtask

  function automatic logic [31:0] outs();
    return {19'd0, cnt_en, cnt_clr, running, lap_active, ovf, disp};
  endfunction

  initial begin
    int n, cnt;
    rst = 1; btn_ss = 0; btn_lap = 0; btn_clr = 0;
    step(); step();
    push("reset_outs", 32'd0); chk(outs());
    rst = 0;
    step(); step();
    push("idle_outs", 32'd0); chk(outs());

    press(0, 1, 0);
    push("lap_in_idle", 32'd0); chk({31'd0, lap_active});

    // Start: running on the press edge, first tick DIV cycles later.
    press(1, 0, 0);
    push("start_running", 32'd1); chk({31'd0, running});
    push("first_tick_lat", DIV); wait_tick(n, 20); chk(n);
    step(); step();
    push("disp_01", 32'h01); chk({24'd0, disp});
    push("tick2_lat", DIV - 2); wait_tick(n, 20); chk(n);
    for (int k = 0; k < 3; k++) begin
      push("tick_period", DIV); wait_tick(n, 20); chk(n);
    end
    // Tick 5 now; pause when pre==2.
    step(); step();
    push("disp_05", 32'h05); chk({24'd0, disp});
    press(1, 0, 0);
    push("paused", 32'd0); chk({31'd0, running});
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (cnt_en) cnt++;
    end
    push("pause_no_ticks", 32'd0); chk(cnt);
    press(1, 0, 0);
    push("resume_partial", 32'd2); wait_tick(n, 20); chk(n);
    push("tick7", DIV); wait_tick(n, 20); chk(n);
    step(); step();
    push("disp_07", 32'h07); chk({24'd0, disp});

    // Lap freeze.
    press(0, 1, 0);
    push("lap_on", 32'd1); chk({31'd0, lap_active});
    wait_chain(8'h12, 100);
    step();
    push("lap_hold_07", 32'h07); chk({24'd0, disp});
    press(0, 1, 0);
    push("lap_off", 32'd0); chk({31'd0, lap_active});
    step();
    push("disp_12", 32'h12); chk({24'd0, disp});

    // Simultaneous buttons: clear wins.
    press(0, 1, 0);
    push("lap_on2", 32'd1); chk({31'd0, lap_active});
    press(1, 1, 1);
    push("clr_state", 32'd0); chk({29'd0, running, lap_active, cnt_clr});
    step();
    push("cnt_clr_pulse", 32'd1); chk({31'd0, cnt_clr});
    step();
    push("cnt_clr_single", 32'd0); chk({31'd0, cnt_clr});
    step();
    push("disp_cleared", 32'h00); chk({24'd0, disp});

    // Overflow at 99.
    press(1, 0, 0);
    wait_chain(8'h99, 700);
`ifdef STOPWATCH_AUTO_STOP_EN
    push("halt_no_tick", 32'hffffffff); wait_tick(n, 12); chk(n);
    push("halt_flags", 32'd1); chk({30'd0, running, ovf});
    push("halt_disp99", 32'h99); chk({24'd0, disp});
    press(1, 0, 0);
    step();
    push("halt_ignores_ss", 32'd0); chk({31'd0, running});
`else
    push("wrap_tick", 32'd3); wait_tick(n, 12); chk(n);
    push("ovf_on_tick", 32'd3); chk({30'd0, running, ovf});
    step(); step();
    push("wrap_disp00", 32'h00); chk({24'd0, disp});
    push("post_wrap_tick", 32'd2); wait_tick(n, 12); chk(n);
    step(); step();
    push("disp01_ovf", 32'h101); chk({23'd0, ovf, disp});
`endif
    press(0, 0, 1);
    push("ovf_cleared", 32'd0); chk({31'd0, ovf});
    step(); step();

    // Reset mid-RUN at 37.
    press(1, 0, 0);
    wait_chain(8'h37, 300);
    push("at_37", 32'h37); chk({24'd0, chain});
    rst = 1;
    step();
    push("midrun_reset", 32'd0); chk(outs());
    rst = 0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (cnt_en || running) cnt++;
    end
    push("stay_idle", 32'd0); chk(cnt);
    press(1, 0, 0);
    push("restart", 32'd1); chk({31'd0, running});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bcd_stopwatch_ctrl.md
# bcd_stopwatch_ctrl

Controller that sequences a cascaded chain of `bcd_1digit` counters as a stopwatch. It converts debounced button pulses into a run/pause/clear state machine. It generates the chain's count-enable tick from a programmable prescaler, and drives a lap-freezable display register from the chain's digit outputs. It sits between the button debouncers and the digit chain / display driver.

## Interface
- `N_DIGITS`, 4: number of BCD digits in the chain (1–8).
- `DIV`, 10: prescaler ratio, `clk` cycles per count tick (minimum 2).

- `clk`  in  1  system clock; all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn_ss`  in  1  start/stop pulse, one cycle wide.
- `btn_lap`  in  1  lap pulse, one cycle wide.
- `btn_clr`  in  1  clear pulse, one cycle wide.
- `digits`  in  4*N_DIGITS  chain value, digit 0 in bits [3:0].
- `cnt_en`  out  1  registered count tick to the chain's `en`.
- `cnt_clr`  out  1  registered one-cycle clear pulse; integration drives each digit's clear from `rst | cnt_clr`.
- `disp`  out  4*N_DIGITS  registered display value.
- `running`  out  1  high in RUN.
- `lap_active`  out  1  display frozen.
- `ovf`  out  1  sticky overflow flag.

## Operation
- States: IDLE (reset, chain at zero), RUN, PAUSE, and HALT (HALT exists only with the macro).
- Event priority within a cycle: `btn_clr` > `btn_ss` > `btn_lap`. A lower-priority button is ignored in a cycle where a higher one is acted on.
- `btn_clr` in any state:
  - next state IDLE;
  - `cnt_clr`=1 for exactly one cycle;
  - prescaler cleared to 0;
  - `lap_active`=0 and `ovf`=0.
- `btn_ss`:
  - IDLE→RUN, PAUSE→RUN, RUN→PAUSE;
  - in HALT, `btn_ss` is ignored.
- `btn_lap`:
  - in RUN, toggles `lap_active`;
  - in IDLE/PAUSE/HALT, clears `lap_active` if set and is otherwise ignored.
- Prescaler `pre` (width ceil(log2(DIV))) behaviour:
  - counts 0..DIV-1 and wraps to 0, only in RUN;
  - holds its value in PAUSE, so a resumed count completes the partial period.
- `cnt_en` is asserted for one cycle in the cycle after `pre`==DIV-1 while in RUN.
- A `btn_ss` pause arriving in the same cycle as `pre`==DIV-1 suppresses that tick.
- `disp` behaviour:
  - when `lap_active`=0, `disp` ← `digits` every cycle;
  - when `lap_active`=1, `disp` holds.
  - Entering lap captures the value registered in the cycle before the press.
- All-nines detection: `digits` == 9 in every nibble, evaluated when the tick is decided.
- Overflow behaviour depends on the macro (see Configuration).

## Timing
- Reset values:
  - state IDLE, `pre`=0;
  - `cnt_en`=0, `cnt_clr`=0;
  - `disp`=0;
  - `running`=0, `lap_active`=0, `ovf`=0.
- Button to state: a button sampled at edge k updates state, `running` and `lap_active` at edge k.
- `cnt_clr` is high during cycle k+1.
- First tick after IDLE→RUN at edge k: `cnt_en` is high in cycle k+DIV.
- Tick period in steady RUN is exactly DIV cycles.
- The chain updates on the edge ending the `cnt_en` cycle, and `digits` is valid the next cycle. `disp` follows one cycle later (2-cycle tick-to-display latency).
- DIV≥2 guarantees `digits` is stable when all-nines is evaluated.
- Reset mid-RUN: all outputs reach their reset values at the reset edge. No `cnt_clr` pulse is generated, because the chain is reset by `rst`.

## Configuration
- `STOPWATCH_AUTO_STOP_EN` defined:
  - a RUN tick decision with all-nines suppresses `cnt_en`;
  - FSM → HALT, `ovf`=1, `running`=0;
  - display saturates at all 9s;
  - only `btn_clr` leaves HALT.
- Not defined:
  - HALT is absent;
  - the tick is issued normally and the chain wraps to all zeros;
  - `ovf` is set in the cycle of that tick and stays set until `btn_clr` or `rst`;
  - FSM stays in RUN.

## Test plan
- Reset, N_DIGITS=2, DIV=4; `btn_ss` at cycle 10 → `running`=1 at cycle 10, `cnt_en` pulses at cycles 14, 18, 22…; `disp` reads 01 at cycle 16.
- RUN to count 05, then `btn_ss` at `pre`=2 → PAUSE with no ticks for 20 cycles. Second `btn_ss` → the next tick comes exactly 2 cycles after resume (prescaler held).
- `btn_lap` at count 07 in RUN → `disp` holds 07 while the chain reaches 12. Second `btn_lap` → `disp`=12 (or current value) one cycle later.
- `btn_clr`, `btn_ss` and `btn_lap` asserted in the same cycle during RUN → IDLE, a single `cnt_clr` pulse, `lap_active`=0, `running`=0.
- Count to 99:
  - with `STOPWATCH_AUTO_STOP_EN`, no further `cnt_en`, HALT, `ovf`=1, `disp`=99, and `btn_ss` is ignored;
  - without it, chain reaches 00, `ovf`=1, counting continues to 01.
- `rst` asserted mid-RUN at count 37 → all outputs at reset values on the next edge. The FSM stays in IDLE until `btn_ss`.
